perf_counter_ctrl: RTL and testbench
====================================

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter NUM_EVT, default 4: number of counters; counter 0 counts cycles, counters 1..NUM_EVT-1 count events.
REQ-002 Parameter CNT_W, default 32: width of every counter and of rd_data.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  level, sampled each edge; request IDLE->RUN.
REQ-006 stop  input  1  level; request RUN->IDLE.
REQ-007 clear  input  1  level; zero all counters and ovf, force IDLE.
REQ-008 halt  input  1  CPU halt indication; RUN->HALTED.
REQ-009 evt  input  NUM_EVT  event strobes; bit i increments counter i; bit 0 unused.
REQ-010 rd_req  input  1  read request, one per cycle allowed.
REQ-011 sel  input  clog2(NUM_EVT)  counter index for rd_req.
REQ-012 rd_valid  output  1  read data valid, registered.
REQ-013 rd_data  output  CNT_W  read data, registered.
REQ-014 running  output  1  high iff state is RUN.
REQ-015 halted  output  1  high iff state is HALTED.
REQ-016 ovf  output  NUM_EVT  sticky wrap flag per counter.

Function
REQ-017 FSM states IDLE, RUN, HALTED; running/halted decode the registered state only.
REQ-018 Per-edge priority: clear > halt > stop > start.
REQ-019 clear=1, any state: next state IDLE, all counters 0, ovf 0.
REQ-020 IDLE: start=1 -> RUN; halt and stop ignored; start and stop both 1 -> RUN (stop has no effect in IDLE).
REQ-021 RUN: halt=1 -> HALTED; else stop=1 -> IDLE; else stay RUN.
REQ-022 HALTED: left only via clear (-> IDLE) or reset; start/stop ignored.
REQ-023 An edge increments counters iff registered state is RUN and clear=0 at that edge; a stop/halt sampled at the same edge still lets that edge count.
REQ-024 Counter 0 increments by 1 on every counting edge.
REQ-025 Counter i (i>=1) increments by 1 on a counting edge where evt[i]=1; evt held high counts every edge.
REQ-026 Counters wrap modulo 2^CNT_W; an increment from all-ones yields 0 and sets ovf[i], which stays set until clear or reset.
REQ-027 rd_req=1 at edge t: at edge t rd_valid<=1 and rd_data<=counter[sel] value before edge t's increment; rd_req=0: rd_valid<=0, rd_data holds.
REQ-028 sel >= NUM_EVT: rd_data<=0, rd_valid<=1.
REQ-029 clear and rd_req same edge: rd_data returns pre-clear value.
REQ-030 Reads never stall counting and are legal in any state.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, all counters 0, ovf 0, rd_valid 0, rd_data 0, running 0, halted 0.
REQ-032 Reset asserted mid-RUN takes effect immediately without waiting for clk; no count occurs while reset=0.
REQ-033 After reset release, the first edge is processed normally (start at that edge -> RUN).

Verification
REQ-034 Reset release, start for 1 cycle, 10 further edges in RUN, stop, rd_req sel=0 -> rd_data=11 (start edge not counted, stop edge counted), running=0.
REQ-035 RUN with evt[2] high for 5 edges, evt[1] pulsed 3 times -> reads of sel=1,2 return 3 and 5; ovf=0.
REQ-036 Preload by running counter 3 near wrap (force CNT_W=8 instance), 256+1 evt[3] edges -> counter 3 = 1, ovf[3]=1, ovf[3] stays 1 after stop; clear -> ovf=0, all reads 0.
REQ-037 RUN, assert halt and stop same edge -> halted=1, running=0; start for 4 edges -> state stays HALTED, counter 0 unchanged; clear -> IDLE.
REQ-038 RUN at counter0=7, rd_req sel=0 together with clear -> rd_data=7, rd_valid=1; next read returns 0.
REQ-039 RUN, drop reset between edges -> running=0 and rd_valid=0 before next edge; after release all reads 0.

Source files
------------

// File: rtl/perf_counter_ctrl_if.sv
// Read port of the performance-counter block.
//   rd_req   : read request, one per cycle allowed
//   sel      : counter index for rd_req (out-of-range reads return 0)
//   rd_valid : registered read-data valid
//   rd_data  : registered read data
// master drives requests and slave returns data.
interface perf_counter_ctrl_if #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32
) ();
  localparam int unsigned SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic             rd_req;
  logic [SEL_W-1:0] sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, output sel, input rd_valid, input rd_data);
  modport slave  (input rd_req, input sel, output rd_valid, output rd_data);
endinterface

// File: rtl/perf_counter_ctrl.sv
// Performance counter controller.
// Counter 0 counts cycles spent in RUN. Counters 1..NUM_EVT-1 count evt[i]
// strobes seen in RUN. Every counter wraps and sets a sticky ovf bit.
// Ports:
//   clk     : single clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : IDLE -> RUN request (level)
//   stop    : RUN -> IDLE request (level)
//   clear   : zero counters and ovf and force IDLE (highest priority)
//   halt    : CPU halt indication, RUN -> HALTED
//   evt     : event strobes; bit 0 is not used
//   rd_bus  : read port (slave modport)
//   running : state is RUN
//   halted  : state is HALTED
//   ovf     : sticky wrap flag per counter
module perf_counter_ctrl #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               halt,
  input  logic [NUM_EVT-1:0] evt,
  perf_counter_ctrl_if.slave rd_bus,
  output logic               running,
  output logic               halted,
  output logic [NUM_EVT-1:0] ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_EVT];
  logic [CNT_W-1:0]   cnt_d [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic               rd_valid_q;
  logic [CNT_W-1:0]   rd_data_q;
  logic [CNT_W-1:0]   rd_mux;
  logic               count_en;

  // Counter 0 always counts, so the strobe on evt[0] has no meaning.
  logic unused_evt0;
  assign unused_evt0 = evt[0];

  // Counting follows the state before this edge, so a stop/halt sampled
  // on the same edge still lets that edge count.
  assign count_en = (state_q == ST_RUN) && !clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (halt)      state_d = ST_HALTED;
          else if (stop) state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) cnt_d[i] = '0;
      ovf_d = '0;
    end else if (count_en) begin
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
        if (i == 0 || evt[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
          if (&cnt_q[i]) ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Reads sample the pre-increment (and pre-clear) counter value.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      if (32'(rd_bus.sel) == i) rd_mux = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NUM_EVT; i++) cnt_q[i] <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (rd_bus.rd_req) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rd_mux;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign running         = (state_q == ST_RUN);
  assign halted          = (state_q == ST_HALTED);
  assign ovf             = ovf_q;
  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
module tb_perf_counter_ctrl;
  localparam int unsigned NUM_EVT = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned MODULUS = 1 << CNT_W;

  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               stop  = 1'b0;
  logic               clear = 1'b0;
  logic               halt  = 1'b0;
  logic [NUM_EVT-1:0] evt   = '0;
  logic               running, halted;
  logic [NUM_EVT-1:0] ovf;

  perf_counter_ctrl_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) rd_if ();

  perf_counter_ctrl #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .halt    (halt),
    .evt     (evt),
    .rd_bus  (rd_if),
    .running (running),
    .halted  (halted),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Behavioural model: mode 0 = idle, 1 = run, 2 = halted.
  int unsigned        m_cnt [NUM_EVT];
  logic [NUM_EVT-1:0] m_ovf;
  int                 m_mode;
  bit                 m_rv;
  int unsigned        m_rd;

  function automatic void model_reset();
    for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = 0;
    m_ovf  = '0;
    m_mode = 0;
    m_rv   = 0;
    m_rd   = 0;
  endfunction

  function automatic void model_edge(bit st, bit sp, bit cl, bit ht,
                                     logic [NUM_EVT-1:0] ev, bit rr, int unsigned sl);
    if (rr) begin
      m_rv = 1;
      if (sl < NUM_EVT) m_rd = m_cnt[sl];
      else              m_rd = 0;
    end else begin
      m_rv = 0;
    end
    if (cl) begin
      for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = 0;
      m_ovf  = '0;
      m_mode = 0;
      return;
    end
    if (m_mode == 1) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        if (i == 0 || ev[i] == 1'b1) begin
          m_cnt[i] = (m_cnt[i] + 1) % MODULUS;
          if (m_cnt[i] == 0) m_ovf[i] = 1'b1;
        end
      end
    end
    case (m_mode)
      0: if (st) m_mode = 1;
      1: if (ht) m_mode = 2; else if (sp) m_mode = 0;
      default: ;
    endcase
  endfunction

  task automatic compare_model(string tag);
    check({tag, ".running"},  running,        (m_mode == 1) ? 1 : 0);
    check({tag, ".halted"},   halted,         (m_mode == 2) ? 1 : 0);
    check({tag, ".ovf"},      ovf,            m_ovf);
    check({tag, ".rd_valid"}, rd_if.rd_valid, m_rv);
    check({tag, ".rd_data"},  rd_if.rd_data,  m_rd);
  endtask

  task automatic step(input bit st, input bit sp, input bit cl, input bit ht,
                      input logic [NUM_EVT-1:0] ev, input bit rr,
                      input logic [SEL_W-1:0] sl, input string tag);
    @(negedge clk);
    start = st; stop = sp; clear = cl; halt = ht; evt = ev;
    rd_if.rd_req = rr; rd_if.sel = sl;
    @(posedge clk);
    model_edge(st, sp, cl, ht, ev, rr, sl);
    #1;
    compare_model(tag);
  endtask

  task automatic nop(input string tag);
    step(0, 0, 0, 0, '0, 0, '0, tag);
  endtask

  task automatic rd(input logic [SEL_W-1:0] sl, input int unsigned exp, input string tag);
    step(0, 0, 0, 0, '0, 1, sl, tag);
    check({tag, ".rd_data_exp"},  rd_if.rd_data, exp);
    check({tag, ".rd_valid_exp"}, rd_if.rd_valid, 1);
  endtask

  typedef struct {
    bit                 st, sp, cl, ht;
    logic [NUM_EVT-1:0] ev;
    bit                 rr;
    logic [SEL_W-1:0]   sl;
    bit                 e_run, e_halt, e_rv;
    int unsigned        e_rd;
    bit                 chk_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit st, bit sp, bit cl, bit ht, bit rr, logic [SEL_W-1:0] sl,
                              bit e_run, bit e_halt, bit e_rv, int unsigned e_rd, bit chk_rd);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.ht = ht; v.ev = '0; v.rr = rr; v.sl = sl;
    v.e_run = e_run; v.e_halt = e_halt; v.e_rv = e_rv; v.e_rd = e_rd; v.chk_rd = chk_rd;
    tbl.push_back(v);
  endfunction

  initial begin
    rd_if.rd_req = 1'b0;
    rd_if.sel    = '0;
    model_reset();

    // Start at the first edge after reset, count 10 edges, stop (counted), read 11.
    add(1,0,0,0, 0,0, 1,0,0, 0,0);
    for (int k = 0; k < 10; k++) add(0,0,0,0, 0,0, 1,0,0, 0,0);
    add(0,1,0,0, 0,0, 0,0,0, 0,0);
    add(0,0,0,0, 1,0, 0,0,1, 11,1);
    add(0,0,0,0, 0,0, 0,0,0, 11,1);
    add(0,0,0,0, 1,6, 0,0,1, 0,1);
    // Halt and stop together from RUN, then start is ignored while halted.
    add(0,0,1,0, 0,0, 0,0,0, 0,1);
    add(1,0,0,0, 0,0, 1,0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,0,0,0, 0,0, 1,0,0, 0,0);
    add(0,1,0,1, 0,0, 0,1,0, 0,0);
    for (int k = 0; k < 4; k++) add(1,0,0,0, 0,0, 0,1,0, 0,0);
    add(0,0,0,0, 1,0, 0,1,1, 4,1);
    add(0,0,1,0, 0,0, 0,0,0, 4,1);
    add(0,0,0,0, 1,0, 0,0,1, 0,1);

    #1;
    check("reset.running",  running, 0);
    check("reset.halted",   halted, 0);
    check("reset.ovf",      ovf, 0);
    check("reset.rd_valid", rd_if.rd_valid, 0);
    check("reset.rd_data",  rd_if.rd_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].st, tbl[k].sp, tbl[k].cl, tbl[k].ht, tbl[k].ev, tbl[k].rr, tbl[k].sl, "tbl");
      check($sformatf("tbl%0d.running", k),  running, tbl[k].e_run);
      check($sformatf("tbl%0d.halted", k),   halted, tbl[k].e_halt);
      check($sformatf("tbl%0d.rd_valid", k), rd_if.rd_valid, tbl[k].e_rv);
      if (tbl[k].chk_rd) check($sformatf("tbl%0d.rd_data", k), rd_if.rd_data, tbl[k].e_rd);
    end

    // evt[2] held for 5 edges, evt[1] pulsed 3 times.
    step(0,0,1,0, '0, 0, '0, "evt");
    step(1,0,0,0, '0, 0, '0, "evt");
    for (int e = 1; e <= 5; e++) begin
      logic [NUM_EVT-1:0] ev;
      ev = 5'b00100;
      if (e % 2 == 1) ev = ev | 5'b00010;
      step(0,0,0,0, ev, 0, '0, "evt");
    end
    step(0,1,0,0, '0, 0, '0, "evt");
    rd(3'd1, 3, "evt.sel1");
    rd(3'd2, 5, "evt.sel2");
    check("evt.ovf", ovf, 0);

    // 257 counted evt[3] edges wrap counter 3 to 1 and set ovf[3].
    step(0,0,1,0, '0, 0, '0, "wrap");
    step(1,0,0,0, '0, 0, '0, "wrap");
    for (int k = 0; k <= 256; k++) step(0, (k == 256), 0, 0, 5'b01000, 0, '0, "wrap");
    check("wrap.running", running, 0);
    rd(3'd3, 1, "wrap.sel3");
    check("wrap.ovf3", ovf[3], 1);
    nop("wrap");
    check("wrap.ovf3_sticky", ovf[3], 1);
    step(0,0,1,0, '0, 0, '0, "wrap");
    check("wrap.ovf_cleared", ovf, 0);
    for (int s = 0; s < NUM_EVT; s++) rd(SEL_W'(s), 0, "wrap.cleared");

    // Read together with clear returns the pre-clear value.
    step(1,0,0,0, '0, 0, '0, "rdclr");
    for (int k = 0; k < 7; k++) nop("rdclr");
    step(0,0,1,0, '0, 1, 3'd0, "rdclr");
    check("rdclr.rd_data",  rd_if.rd_data, 7);
    check("rdclr.rd_valid", rd_if.rd_valid, 1);
    check("rdclr.running",  running, 0);
    rd(3'd0, 0, "rdclr.after");

    // Asynchronous reset between edges while running.
    step(1,0,0,0, '0, 0, '0, "arst");
    for (int k = 0; k < 4; k++) nop("arst");
    step(0,0,0,0, 5'b11110, 1, 3'd0, "arst");
    check("arst.pre_valid", rd_if.rd_valid, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst.running",  running, 0);
    check("arst.rd_valid", rd_if.rd_valid, 0);
    check("arst.rd_data",  rd_if.rd_data, 0);
    check("arst.ovf",      ovf, 0);
    model_reset();
    start = 1'b1; evt = '1;
    @(posedge clk);
    #1 check("arst.held_running", running, 0);
    start = 1'b0; evt = '0; rd_if.rd_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int s = 0; s < NUM_EVT; s++) rd(SEL_W'(s), 0, "arst.read");

    // Random stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 40) == 0,
           ($urandom % 24) == 0, NUM_EVT'($urandom), $urandom % 2,
           SEL_W'($urandom_range(0, 7)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
